// File: rtl/sram_port.sv
// sram_port: word-addressed SRAM behind a request/busy handshake that inserts
// LATENCY wait states per access. Build option: define SRAM_ERR_EN to add the
// err output, which flags misaligned or out-of-range addresses and blocks the
// access.
`timescale 1ns/1ps
module sram_port #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Ren,
  input  logic        Wen,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic        busy_o
`ifdef SRAM_ERR_EN
  ,
  output logic        err
`endif
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [31:0] ERR_WORD = 32'hBAD1_BAD1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic          accept;
  logic          req;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic          wr_q;
  logic [31:0]   load_q;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          bad;

  assign req = Ren | Wen;
  assign idx = addr_q[AW+1:2];

`ifdef SRAM_ERR_EN
  // Misaligned byte address, or bits set above the word index.
  assign bad = (addr_q[1:0] != 2'b00) || ((addr_q >> (AW + 2)) != 32'd0);
  assign err = (state == DONE) && bad;
`else
  // Without checking, the bits outside the index are ignored so the
  // address simply wraps modulo DEPTH.
  logic unused_addr_bits;
  assign bad              = 1'b0;
  assign unused_addr_bits = ^{addr_q[1:0], addr_q[31:AW+2]};
`endif

  // busy_o is high while a request is being accepted or is in its wait states.
  assign busy_o = ((state == IDLE) && req) || (state == WAIT);

  // Next-state logic: accept, count wait states, abort on a dropped request.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY > 0) begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end else begin
            state_n = DONE;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Capture the request at acceptance; later input changes are ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q <= 32'd0;
      data_q <= 32'd0;
      wr_q   <= 1'b0;
    end else if (accept) begin
      addr_q <= ramaddr;
      data_q <= ramstore;
      wr_q   <= Wen;
    end
  end

  // Hold the last read (or error word) until the next completed access.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      load_q <= 32'd0;
    end else if (state == DONE) begin
      if (bad) begin
        load_q <= ERR_WORD;
      end else if (!wr_q) begin
        load_q <= mem[idx];
      end
    end
  end

  // Storage array: written at the DONE edge, never reset.
  always_ff @(posedge CLK) begin
    if ((state == DONE) && wr_q && !bad && !RST) begin
      mem[idx] <= data_q;
    end
  end

  // Read data is visible during the DONE cycle itself, then held.
  always_comb begin
    ramload = load_q;
    if (state == DONE) begin
      if (bad) begin
        ramload = ERR_WORD;
      end else if (!wr_q) begin
        ramload = mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_sram_port.sv
// tb_sram_port: directed bench for sram_port. Two instances (LATENCY 2 and 0)
// are checked every cycle against a transaction-level model, plus literal
// expectations for the key scenarios.
`timescale 1ns/1ps
module tb_sram_port;
`ifdef SRAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ren  [2];
  logic        wen  [2];
  logic [31:0] addr [2];
  logic [31:0] data [2];
  logic [31:0] rl   [2];
  logic        busy [2];
`ifdef SRAM_ERR_EN
  logic        err  [2];
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Transaction model state, per instance
  int          age      [2];
  logic [31:0] m_addr   [2];
  logic [31:0] m_data   [2];
  bit          m_wr     [2];
  logic [31:0] mem      [2][256];
  bit          known    [2][256];
  logic [31:0] ld       [2];
  bit          ld_known [2];

  sram_port #(.LATENCY(2), .DEPTH(256)) ua (
    .CLK(clk), .RST(rst), .Ren(ren[0]), .Wen(wen[0]),
    .ramaddr(addr[0]), .ramstore(data[0]), .ramload(rl[0]), .busy_o(busy[0])
`ifdef SRAM_ERR_EN
    , .err(err[0])
`endif
  );

  sram_port #(.LATENCY(0), .DEPTH(256)) ub (
    .CLK(clk), .RST(rst), .Ren(ren[1]), .Wen(wen[1]),
    .ramaddr(addr[1]), .ramstore(data[1]), .ramload(rl[1]), .busy_o(busy[1])
`ifdef SRAM_ERR_EN
    , .err(err[1])
`endif
  );

  always #5 clk = ~clk;

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic bit bad_addr(input logic [31:0] a);
    return ERR_EN && ((a[1:0] != 2'b00) || (a[31:10] != 22'd0));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      age[k] = -1; ld[k] = 32'd0; ld_known[k] = 1'b1;
      m_addr[k] = 32'd0; m_data[k] = 32'd0; m_wr[k] = 1'b0;
    end
  endtask

  // One clock of protocol: accept, wait LATENCY cycles, complete.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int i;
      bit req;
      req = ren[k] | wen[k];
      i = int'(m_addr[k][9:2]);
      if (age[k] < 0) begin
        if (req) begin
          m_addr[k] = addr[k]; m_data[k] = data[k]; m_wr[k] = wen[k]; age[k] = 1;
        end
      end else if (age[k] <= lat(k)) begin
        if (!req) age[k] = -1;
        else age[k]++;
      end else begin
        if (bad_addr(m_addr[k])) begin
          ld[k] = 32'hBAD1BAD1; ld_known[k] = 1'b1;
        end else if (m_wr[k]) begin
          mem[k][i] = m_data[k]; known[k][i] = 1'b1;
        end else begin
          ld[k] = mem[k][i]; ld_known[k] = known[k][i];
        end
        age[k] = -1;
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] erl;
      bit ek, eb, done;
      int i;
      i = int'(m_addr[k][9:2]);
      erl = ld[k]; ek = ld_known[k]; eb = 1'b0;
      done = (age[k] > lat(k));
      if (age[k] < 0) eb = ren[k] | wen[k];
      else if (!done) eb = 1'b1;
      else if (bad_addr(m_addr[k])) begin
        erl = 32'hBAD1BAD1; ek = 1'b1;
      end else if (!m_wr[k]) begin
        erl = mem[k][i]; ek = known[k][i];
      end
      chk($sformatf("busy_o[%0d]", k), 32'(busy[k]), 32'(eb));
      if (ek) chk($sformatf("ramload[%0d]", k), rl[k], erl);
`ifdef SRAM_ERR_EN
      chk($sformatf("err[%0d]", k), 32'(err[k]), 32'(done && bad_addr(m_addr[k])));
`endif
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) compare();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    ren[k] = r; wen[k] = w; addr[k] = a; data[k] = d;
  endtask

  // Full access: request held through the wait states, dropped in DONE,
  // with address/data scrambled after acceptance. Returns ramload in DONE.
  task automatic acc(input int k, input bit r, input bit w,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] ld_done);
    drive(k, r, w, a, d);
    for (int i = 0; i < lat(k); i++) begin
      tick();
      drive(k, r, w, a ^ 32'h0000_03F0, ~d);
    end
    tick();
    drive(k, 1'b0, 1'b0, a ^ 32'h0000_00F0, d);
    @(negedge clk);
    ld_done = rl[k];
    chk("done_busy", 32'(busy[k]), 32'd0);
    tick();
  endtask

  initial begin
    logic [31:0] v;
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 1'b0, 32'd0, 32'd0);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_load_a", rl[0], 32'd0);
    chk("reset_load_b", rl[1], 32'd0);
    chk("reset_busy_a", 32'(busy[0]), 32'd0);
    chk("reset_busy_b", 32'(busy[1]), 32'd0);
    tick(); rst = 1'b0;
    tick();

    // Write 0x10 with two wait states, inputs changed mid-access
    drive(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk); chk("w10_busy_req", 32'(busy[0]), 32'd1);
    tick(); drive(0, 1'b0, 1'b1, 32'h14, 32'h0);
    @(negedge clk); chk("w10_busy_wait1", 32'(busy[0]), 32'd1);
    tick(); drive(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk); chk("w10_busy_wait2", 32'(busy[0]), 32'd1);
    tick(); drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("w10_busy_done", 32'(busy[0]), 32'd0);
    chk("w10_load_unchanged", rl[0], 32'd0);
    tick();
    acc(0, 1'b1, 1'b0, 32'h10, 32'h0, v); chk("r10", v, 32'hDEADBEEF);
    @(negedge clk); chk("r10_hold", rl[0], 32'hDEADBEEF);
    tick();

    // Read and write together: the write wins
    acc(0, 1'b1, 1'b1, 32'h20, 32'h1234, v); chk("rw20_load", v, 32'hDEADBEEF);
    acc(0, 1'b1, 1'b0, 32'h20, 32'h0, v);    chk("r20", v, 32'h00001234);

    // Abort: request dropped in the second wait cycle
    acc(0, 1'b0, 1'b1, 32'h40, 32'hA0A0A0A0, v);
    drive(0, 1'b0, 1'b1, 32'h40, 32'h5555);
    tick(); tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    @(negedge clk); chk("abort_idle_busy", 32'(busy[0]), 32'd0);
    tick();
    acc(0, 1'b1, 1'b0, 32'h40, 32'h0, v); chk("r40_after_abort", v, 32'hA0A0A0A0);

    // Reset during the wait state of a write
    acc(0, 1'b0, 1'b1, 32'h44, 32'h44444444, v);
    drive(0, 1'b0, 1'b1, 32'h44, 32'h77);
    tick();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rst_mid_load", rl[0], 32'd0);
    chk("rst_mid_busy", 32'(busy[0]), 32'd0);
    tick(); rst = 1'b0;
    tick();
    acc(0, 1'b1, 1'b0, 32'h44, 32'h0, v); chk("r44_after_rst", v, 32'h44444444);

    // Address outside the index
    acc(0, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, v);
`ifdef SRAM_ERR_EN
    acc(0, 1'b0, 1'b1, 32'h3, 32'h99, v);    chk("err_w3_load", v, 32'hBAD1BAD1);
    acc(0, 1'b1, 1'b0, 32'h0, 32'h0, v);     chk("r0_not_written", v, 32'hCAFEF00D);
    acc(0, 1'b1, 1'b0, 32'h400, 32'h0, v);   chk("err_r400", v, 32'hBAD1BAD1);
`else
    acc(0, 1'b1, 1'b0, 32'h400, 32'h0, v);   chk("wrap_r400", v, 32'hCAFEF00D);
    acc(0, 1'b1, 1'b0, 32'h8000_0011, 32'h0, v); chk("wrap_r80000011", v, 32'hDEADBEEF);
`endif

    // Zero wait states, back-to-back reads
    acc(1, 1'b0, 1'b1, 32'h8, 32'h11111111, v); chk("b_w8_load", v, 32'd0);
    acc(1, 1'b0, 1'b1, 32'hC, 32'h22222222, v);
    drive(1, 1'b1, 1'b0, 32'h8, 32'h0);
    @(negedge clk); chk("b2b_busy0", 32'(busy[1]), 32'd1);
    tick();
    @(negedge clk);
    chk("b2b_busy1", 32'(busy[1]), 32'd0);
    chk("b2b_load1", rl[1], 32'h11111111);
    drive(1, 1'b1, 1'b0, 32'hC, 32'h0);
    tick();
    @(negedge clk); chk("b2b_busy2", 32'(busy[1]), 32'd1);
    tick();
    @(negedge clk);
    chk("b2b_busy3", 32'(busy[1]), 32'd0);
    chk("b2b_load3", rl[1], 32'h22222222);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
